// File: rtl/core_pkg.sv
// Shared pipeline types: write-back select, operand forward select and hazard FSM state.
package core_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_CSR = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/fwd_unit.sv
// Operand forward select for one execute-stage source register; memory stage wins over write-back.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             regwe_m,
  input  logic [REG_W-1:0] rd_m,
  input  logic             regwe_w,
  input  logic [REG_W-1:0] rd_w,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_NONE;
    if (regwe_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (regwe_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use interlock, branch flush
// and data-memory wait handling with a bounded wait timeout.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic             regwe_e,
  input  logic             regwe_m,
  input  logic             regwe_w,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic [1:0]       wb_sel_e,
  input  logic             pc_src_e,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_err
);

  hz_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             timeout;
  logic             mem_stall;
  logic             lu_stall;
  fwd_sel_t         sel_a, sel_b;

  fwd_unit u_fwd_a (
    .rs      (rs1_e),
    .regwe_m (regwe_m),
    .rd_m    (rd_m),
    .regwe_w (regwe_w),
    .rd_w    (rd_w),
    .sel     (sel_a)
  );

  fwd_unit u_fwd_b (
    .rs      (rs2_e),
    .regwe_m (regwe_m),
    .rd_m    (rd_m),
    .regwe_w (regwe_w),
    .rd_w    (rd_w),
    .sel     (sel_b)
  );

  // Forward selects are pure functions of the stage registers, blanked during reset.
  assign fwd_a_e = rst_in ? FWD_NONE : sel_a;
  assign fwd_b_e = rst_in ? FWD_NONE : sel_b;

  assign lu_stall = (wb_sel_e == WB_MEM) && regwe_e && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  assign timeout = (state == MEM_WAIT) && !mem_ready_m &&
                   (cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    mem_stall  = 1'b0;
    mem_err    = 1'b0;
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    stall_e    = 1'b0;
    stall_m    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    flush_w    = 1'b0;

    case (state)
      IDLE: begin
        if (mem_req_m && !mem_ready_m) begin
          state_next = MEM_WAIT;
          cnt_next   = '0;
          mem_stall  = 1'b1;
        end
      end
      MEM_WAIT: begin
        cnt_next = cnt + CNT_W'(1);
        mem_err  = timeout;
        if (mem_ready_m || timeout) begin
          state_next = IDLE;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // A held E register keeps pc_src_e asserted, so a branch during a memory
    // stall is flushed naturally in the first cycle the stall lifts.
    if (rst_in) begin
      mem_err = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lu_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int unsigned TB_WAIT = 15;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwe_e, regwe_m, regwe_w;
  logic [1:0] wb_sel_e;
  logic       pc_src_e, mem_req_m, mem_ready_m;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w, mem_err;

  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          pend = 0;   // cycles the outstanding access has already been stalled
  logic        done = 1'b0;

  always #5 clk_in = ~clk_in;

  hazard_ctrl #(.WAIT_MAX(TB_WAIT)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .regwe_e(regwe_e), .regwe_m(regwe_m), .regwe_w(regwe_w),
    .rd_m(rd_m), .rd_w(rd_w), .wb_sel_e(wb_sel_e), .pc_src_e(pc_src_e),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w), .mem_err(mem_err)
  );

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (regwe_m && rd_m != 5'd0 && rd_m == rs) return FWD_M;
    if (regwe_w && rd_w != 5'd0 && rd_w == rs) return FWD_W;
    return FWD_NONE;
  endfunction

  task automatic idle_inputs();
    rst_in = 1'b0;
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
    rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
    regwe_e = 1'b0; regwe_m = 1'b0; regwe_w = 1'b0;
    wb_sel_e = WB_ALU; pc_src_e = 1'b0; mem_req_m = 1'b0; mem_ready_m = 1'b0;
  endtask

  // Reference model for one cycle: push the expected outputs, advance, then step the clock.
  task automatic apply(input string tag);
    logic [1:0] fa, fb;
    logic sf, sd, se, sm, fd, fe, fw, me, ms, lu;
    fa = FWD_NONE; fb = FWD_NONE;
    sf = 0; sd = 0; se = 0; sm = 0; fd = 0; fe = 0; fw = 0; me = 0; ms = 0; lu = 0;
    if (rst_in) begin
      fd = 1; fe = 1; fw = 1;
      pend = 0;
    end else begin
      fa = fwd_ref(rs1_e);
      fb = fwd_ref(rs2_e);
      if (pend == 0) begin
        if (mem_req_m && !mem_ready_m) begin ms = 1; pend = 1; end
      end else if (mem_ready_m) begin
        pend = 0;
      end else if (pend == int'(TB_WAIT)) begin
        me = 1; pend = 0;
      end else begin
        ms = 1; pend++;
      end
      lu = (wb_sel_e == WB_MEM) && regwe_e && rd_e != 5'd0 &&
           (rd_e == rs1_d || rd_e == rs2_d);
      if (ms) begin
        sf = 1; sd = 1; se = 1; sm = 1; fw = 1;
      end else if (pc_src_e) begin
        fd = 1; fe = 1;
      end else if (lu) begin
        sf = 1; sd = 1; fe = 1;
      end
    end
    exp_q.push_back({fa, fb, sf, sd, se, sm, fd, fe, fw, me});
    tag_q.push_back(tag);
    @(posedge clk_in); #1;
  endtask

  // Monitor: compare every presented output cycle against the scoreboard.
  always @(negedge clk_in) begin
    logic [11:0] act, exp_v;
    string t;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      t = tag_q.pop_front();
      act = {fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
             flush_d, flush_e, flush_w, mem_err};
      n_checks++;
      if (act !== exp_v) begin
        n_errors++;
        $display("FAIL %s: got %b expected %b (fa fb sf sd se sm fd fe fw err)", t, act, exp_v);
      end
    end else if (done) begin
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

  initial begin
    idle_inputs();
    rst_in = 1'b1;
    @(posedge clk_in); #1;

    // reset overrides a pending branch, a memory request and a forward hit
    pc_src_e = 1; mem_req_m = 1; regwe_m = 1; rd_m = 5'd1; rs1_e = 5'd1;
    apply("reset");
    idle_inputs();
    apply("idle");

    regwe_m = 1; rd_m = 5'd5; rs1_e = 5'd5; regwe_w = 1; rd_w = 5'd5;
    #1;
    n_checks++;
    if (fwd_a_e !== FWD_M) begin
      n_errors++;
      $display("FAIL direct fwd_a_m: got %b", fwd_a_e);
    end
    apply("fwd_a_m");
    rd_m = 5'd0;
    #1;
    n_checks++;
    if (fwd_a_e !== FWD_W) begin
      n_errors++;
      $display("FAIL direct fwd_a_w: got %b", fwd_a_e);
    end
    apply("fwd_a_w");
    rs1_e = 5'd0; rs2_e = 5'd5; rd_m = 5'd5;
    apply("fwd_b_m");
    regwe_m = 0;
    apply("fwd_b_w");
    rd_w = 5'd0;
    apply("fwd_x0_none");

    idle_inputs();
    wb_sel_e = WB_MEM; regwe_e = 1; rd_e = 5'd3; rs2_d = 5'd3;
    #1;
    n_checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111) begin
      n_errors++;
      $display("FAIL direct lu_stall: sf=%b sd=%b fe=%b", stall_f, stall_d, flush_e);
    end
    apply("lu_stall");
    wb_sel_e = WB_ALU; regwe_e = 0; rd_e = 5'd0;
    apply("lu_release");
    wb_sel_e = WB_MEM; regwe_e = 1; rd_e = 5'd0; rs1_d = 5'd0;
    apply("lu_x0");

    idle_inputs();
    mem_req_m = 1;
    repeat (3) apply("mem_wait3");
    mem_ready_m = 1;
    #1;
    n_checks++;
    if (stall_m !== 1'b0 || mem_err !== 1'b0) begin
      n_errors++;
      $display("FAIL direct mem_ready: sm=%b err=%b", stall_m, mem_err);
    end
    apply("mem_ready");
    idle_inputs();
    apply("mem_after");

    mem_req_m = 1;
    repeat (16) apply("mem_timeout");
    idle_inputs();
    apply("timeout_after");

    wb_sel_e = WB_MEM; regwe_e = 1; rd_e = 5'd7; rs1_d = 5'd7; pc_src_e = 1;
    #1;
    n_checks++;
    if ({flush_d, flush_e, stall_f} !== 3'b110) begin
      n_errors++;
      $display("FAIL direct br_over_lu: fd=%b fe=%b sf=%b", flush_d, flush_e, stall_f);
    end
    apply("br_over_lu");
    idle_inputs();
    mem_req_m = 1; pc_src_e = 1;
    repeat (2) apply("br_in_stall");
    mem_ready_m = 1;
    apply("br_released");
    idle_inputs();
    apply("br_done");

    mem_req_m = 1;
    repeat (4) apply("pre_rst");
    rst_in = 1;
    apply("rst_mid_wait");
    idle_inputs();
    apply("post_rst");
    mem_req_m = 1;
    repeat (16) apply("timeout_after_rst");
    idle_inputs();
    apply("idle_end");

    for (int i = 0; i < 600; i++) begin
      rst_in      = ($urandom_range(0, 59) == 0);
      rs1_d       = 5'($urandom_range(0, 3));
      rs2_d       = 5'($urandom_range(0, 3));
      rs1_e       = 5'($urandom_range(0, 3));
      rs2_e       = 5'($urandom_range(0, 3));
      rd_e        = 5'($urandom_range(0, 3));
      rd_m        = 5'($urandom_range(0, 3));
      rd_w        = 5'($urandom_range(0, 3));
      regwe_e     = 1'($urandom_range(0, 1));
      regwe_m     = 1'($urandom_range(0, 1));
      regwe_w     = 1'($urandom_range(0, 1));
      wb_sel_e    = 2'($urandom_range(0, 3));
      pc_src_e    = ($urandom_range(0, 7) == 0);
      mem_req_m   = ($urandom_range(0, 2) == 0);
      mem_ready_m = ($urandom_range(0, 7) == 0);
      apply("random");
    end

    idle_inputs();
    done = 1'b1;
    repeat (5) @(posedge clk_in);
    $display("FAIL monitor: summary not reached, %0d entries left", exp_q.size());
    $fatal(1, "monitor did not drain the scoreboard");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, the maximum number of data-memory wait cycles before timeout (range 1..255).
REQ-002 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports rs1_d, rs2_d  input  5 each  source register addresses in decode.
REQ-005 SHALL have ports rs1_e, rs2_e, rd_e  input  5 each  source and destination register addresses in execute.
REQ-006 SHALL have ports regwe_e, regwe_m, regwe_w  input  1 each  register write enable for the execute, memory and write-back stages.
REQ-007 SHALL have ports rd_m, rd_w  input  5 each  destination register address for the memory and write-back stages.
REQ-008 SHALL have port wb_sel_e  input  2  write-back select in execute; WB_MEM marks a load.
REQ-009 SHALL have port pc_src_e  input  1  taken branch or jump resolved in execute.
REQ-010 SHALL have ports mem_req_m  input  1  (memory-stage load/store active) and mem_ready_m  input  1  (data memory completes this cycle).
REQ-011 SHALL have ports fwd_a_e, fwd_b_e  output  2 each  operand forward selects: FWD_NONE, FWD_M, or FWD_W.
REQ-012 SHALL have ports stall_f, stall_d, stall_e, stall_m  output  1 each  hold the corresponding pipeline register.
REQ-013 SHALL have ports flush_d, flush_e, flush_w  output  1 each  insert a bubble into the corresponding stage.
REQ-014 SHALL have port mem_err  output  1  one-cycle memory timeout pulse.

Function
REQ-015 SHALL drive fwd_a_e = FWD_M when regwe_m, rd_m!=0 and rd_m==rs1_e; otherwise FWD_W when regwe_w, rd_w!=0 and rd_w==rs1_e; otherwise FWD_NONE. M takes priority over W.
REQ-016 SHALL compute fwd_b_e identically, using rs2_e in place of rs1_e.
REQ-017 SHALL assert lu_stall when wb_sel_e==WB_MEM, regwe_e, rd_e!=0 and rd_e equals rs1_d or rs2_d; this is a combinational load-use detection.
REQ-018 SHALL implement an FSM with states IDLE and MEM_WAIT.
REQ-019 SHALL transition IDLE->MEM_WAIT when mem_req_m is high and mem_ready_m is low.
REQ-020 SHALL transition MEM_WAIT->IDLE on mem_ready_m or on timeout.
REQ-021 SHALL define mem_stall = (state==IDLE & mem_req_m & ~mem_ready_m) | (state==MEM_WAIT & ~mem_ready_m & ~timeout); a zero-wait access never stalls.
REQ-022 SHALL clear the 8-bit wait counter on IDLE->MEM_WAIT, increment it each cycle in MEM_WAIT, and set timeout when the counter equals WAIT_MAX-1 with mem_ready_m low.
REQ-023 SHALL pulse mem_err for exactly one cycle on the timeout cycle; the FSM returns to IDLE and the pipeline proceeds.
REQ-024 SHALL, during mem_stall, assert stall_f, stall_d, stall_e, stall_m and flush_w; mem_stall overrides every other stall or flush.
REQ-025 SHALL, when lu_stall is high and mem_stall is low, assert stall_f, stall_d and flush_e.
REQ-026 SHALL, when pc_src_e is high and mem_stall is low, assert flush_d and flush_e and leave stall_f low; pc_src_e overrides lu_stall.
REQ-027 SHALL keep pc_src_e pending while mem_stall is high: flushes are issued in the first non-stalled cycle, because the upstream E register is held.
REQ-028 SHALL keep all outputs other than the forward selects combinational from inputs and current state, with no added latency.

Reset
REQ-029 SHALL, while rst_in is high at a clock edge, set state=IDLE and wait counter=0.
REQ-030 SHALL, in the reset cycle, drive all stall_* =0, flush_d=flush_e=flush_w=1, mem_err=0 and fwd_*=FWD_NONE.
REQ-031 SHALL abandon any MEM_WAIT in progress on reset, without raising mem_err.

Structure
REQ-032 SHALL place the wb_sel_t enum (WB_ALU, WB_MEM, WB_PC4, WB_CSR), the fwd_sel_t enum and the hz_state_t enum in shared package core_pkg.
REQ-033 SHALL implement forwarding in sub-module fwd_unit, instantiated twice (operand A and operand B); all sequential logic stays in hazard_ctrl.

Verification
REQ-034 SHALL cover: regwe_m=1, rd_m=5, rs1_e=5 and regwe_w=1, rd_w=5 -> fwd_a_e=FWD_M; with rd_m=0 -> FWD_W.
REQ-035 SHALL cover: load to x3 in E, rs2_d=3 -> stall_f=stall_d=flush_e=1 for exactly one cycle.
REQ-036 SHALL cover: mem_req_m held, mem_ready_m high after 3 cycles -> 3 stall cycles then IDLE, mem_err=0.
REQ-037 SHALL cover: mem_req_m held, mem_ready_m never high, WAIT_MAX=15 -> mem_err pulses once, 15 cycles after the request, then stalls drop.
REQ-038 SHALL cover: pc_src_e=1 together with lu_stall -> flush_d=flush_e=1, stall_f=0; during mem_stall -> flushes delayed until ready.
REQ-039 SHALL cover: rst_in asserted mid-MEM_WAIT -> next cycle state IDLE, counter 0, no mem_err.
